// File: rtl/npu_seq_pkg.sv
// Shared types and default sizes for the npu_seq_ctrl sequencer.
package npu_seq_pkg;
  localparam int IN_BYTES_D  = 65536;
  localparam int OUT_WORDS_D = 8192;
  localparam int LANES_D     = 4;
  localparam int LANE_W      = 16;
  localparam int BYTE_W      = 8;

  typedef enum logic [2:0] {
    IDLE, LOAD, PROC_RUN, PROC_GAP, SEND_RD, SEND_TX, SEND_WAIT, DONE
  } seq_state_t;
endpackage

// File: rtl/npu_seq_ctrl_if.sv
// Bus between the sequencer (master) and the UART/memory/NPU environment (slave).
interface npu_seq_ctrl_if #(
  parameter int LANES  = npu_seq_pkg::LANES_D,
  parameter int ADDR_W = 16
);
  import npu_seq_pkg::*;

  logic                          start;
  logic                          rx_done;
  logic [BYTE_W-1:0]             rx_data;
  logic                          in_we;
  logic [ADDR_W-1:0]             in_addr;
  logic [BYTE_W-1:0]             in_wdata;
  logic                          npu_en;
  logic                          npu_done;
  logic                          out_we;
  logic [ADDR_W-1:0]             out_addr;
  logic [LANES-1:0][LANE_W-1:0]  out_rdata;
  logic [BYTE_W-1:0]             tx_data;
  logic                          tx_en;
  logic                          tx_done;
  logic                          busy;
  logic                          done;
  logic                          err_overrun;

  modport master (
    input  start, rx_done, rx_data, npu_done, out_rdata, tx_done,
    output in_we, in_addr, in_wdata, npu_en, out_we, out_addr,
           tx_data, tx_en, busy, done, err_overrun
  );

  modport slave (
    output start, rx_done, rx_data, npu_done, out_rdata, tx_done,
    input  in_we, in_addr, in_wdata, npu_en, out_we, out_addr,
           tx_data, tx_en, busy, done, err_overrun
  );
endinterface

// File: rtl/npu_seq_tx_ser.sv
// Holds one output-memory word and steps through its bytes, low byte of lane 0 first.
module npu_seq_tx_ser
  import npu_seq_pkg::*;
#(
  parameter int LANES = LANES_D
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic                         fire,
  input  logic                         wait_st,
  input  logic                         tx_done,
  input  logic [LANES-1:0][LANE_W-1:0] word,
  output logic                         tx_en,
  output logic [BYTE_W-1:0]            tx_data,
  output logic                         last_byte
);
  localparam int NB    = 2 * LANES;
  localparam int SEL_W = $clog2(NB);

  // Byte view of the latched word: byte k is lane k/2, low half first.
  logic [NB-1:0][BYTE_W-1:0] word_q;
  logic [SEL_W-1:0]          byte_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q   <= '0;
      byte_sel <= '0;
    end else if (load) begin
      word_q   <= word;
      byte_sel <= '0;
    end else if (wait_st && tx_done && !last_byte) begin
      byte_sel <= byte_sel + 1'b1;
    end
  end

  assign last_byte = (byte_sel == SEL_W'(NB - 1));
  assign tx_en     = fire;
  assign tx_data   = word_q[byte_sel];
endmodule

// File: rtl/npu_seq_ctrl.sv
// UART -> input memory -> NPU -> output memory -> UART sequencer, one explicit FSM.
// Define NPU_SEQ_CHECKSUM_EN to append an XOR checksum byte after the data bytes.
module npu_seq_ctrl
  import npu_seq_pkg::*;
#(
  parameter int IN_BYTES  = IN_BYTES_D,
  parameter int OUT_WORDS = OUT_WORDS_D,
  parameter int LANES     = LANES_D,
  parameter int ADDR_W    = 16
) (
  input  logic           clk,
  input  logic           rst,
  npu_seq_ctrl_if.master bus
);
  localparam int CNT_W = $clog2(IN_BYTES) + 1;
  localparam int IDX_W = $clog2(OUT_WORDS) + 1;

  seq_state_t        state, state_nx;
  logic [CNT_W-1:0]  byte_cnt;
  logic [IDX_W-1:0]  blk_idx, word_idx;
  logic              in_we_q, err_q;
  logic [ADDR_W-1:0] in_addr_q;
  logic [BYTE_W-1:0] in_wdata_q;

  logic              start_acc, load_full, rx_take, last_blk, last_word, send_last;
  logic              ser_load, ser_fire, ser_wait, ser_last, cks_pend;
  logic [BYTE_W-1:0] ser_data;
  logic              npu_en_c, out_we_c, busy_c, done_c;
  logic [ADDR_W-1:0] in_addr_c, out_addr_c;

  assign start_acc = bus.start && (state == IDLE || state == DONE);
  assign load_full = (byte_cnt == CNT_W'(IN_BYTES));
  assign rx_take   = bus.rx_done && state == LOAD && !load_full;
  assign last_blk  = (blk_idx == IDX_W'(OUT_WORDS - 1));
  assign last_word = (word_idx == IDX_W'(OUT_WORDS - 1));
  assign send_last = state == SEND_WAIT && bus.tx_done && ser_last && last_word;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (bus.start) state_nx = LOAD;
      // load_full first holds in the cycle the final byte is written
      LOAD:       if (load_full) state_nx = PROC_RUN;
      PROC_RUN:   if (bus.npu_done) state_nx = PROC_GAP;
      PROC_GAP:   state_nx = last_blk ? SEND_RD : PROC_RUN;
      SEND_RD:    state_nx = SEND_TX;
      SEND_TX:    state_nx = SEND_WAIT;
      SEND_WAIT:
        if (bus.tx_done) begin
          if (!ser_last)      state_nx = SEND_TX;
          else if (!last_word) state_nx = SEND_RD;
          else if (cks_pend)  state_nx = SEND_TX;
          else                state_nx = DONE;
        end
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    npu_en_c   = 1'b0;
    out_we_c   = 1'b0;
    busy_c     = 1'b1;
    done_c     = 1'b0;
    ser_load   = 1'b0;
    ser_fire   = 1'b0;
    ser_wait   = 1'b0;
    in_addr_c  = in_addr_q;
    out_addr_c = '0;
    case (state)
      IDLE: busy_c = 1'b0;
      DONE: begin
        busy_c = 1'b0;
        done_c = 1'b1;
      end
      PROC_RUN: begin
        npu_en_c   = 1'b1;
        out_we_c   = bus.npu_done;
        in_addr_c  = ADDR_W'({blk_idx, 1'b0});
        out_addr_c = ADDR_W'(blk_idx);
      end
      // The read address leads SEND_RD by a cycle so the 1-cycle-latency
      // read data is already on out_rdata when SEND_RD latches it.
      PROC_GAP:  out_addr_c = last_blk ? ADDR_W'(word_idx) : ADDR_W'(blk_idx);
      SEND_RD: begin
        ser_load   = 1'b1;
        out_addr_c = ADDR_W'(word_idx);
      end
      SEND_TX: begin
        ser_fire   = 1'b1;
        out_addr_c = ADDR_W'(word_idx);
      end
      SEND_WAIT: begin
        ser_wait   = 1'b1;
        out_addr_c = (ser_last && !last_word) ? ADDR_W'(word_idx + 1'b1)
                                              : ADDR_W'(word_idx);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt   <= '0;
      blk_idx    <= '0;
      word_idx   <= '0;
      in_we_q    <= 1'b0;
      in_addr_q  <= '0;
      in_wdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      in_we_q <= rx_take;
      if (rx_take) begin
        in_addr_q  <= ADDR_W'(byte_cnt);
        in_wdata_q <= bus.rx_data;
        byte_cnt   <= byte_cnt + 1'b1;
      end
      if (state == PROC_GAP) begin
        blk_idx <= blk_idx + 1'b1;
        if (last_blk) word_idx <= '0;
      end
      if (state == SEND_WAIT && bus.tx_done && ser_last && !last_word)
        word_idx <= word_idx + 1'b1;
      // A byte with nowhere to go is dropped and flagged.
      if (bus.rx_done && (state != LOAD || load_full)) err_q <= 1'b1;
      if (start_acc) begin
        byte_cnt  <= '0;
        blk_idx   <= '0;
        word_idx  <= '0;
        in_addr_q <= '0;
        err_q     <= 1'b0;
      end
    end
  end

  npu_seq_tx_ser #(.LANES(LANES)) u_tx_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load),
    .fire      (ser_fire),
    .wait_st   (ser_wait),
    .tx_done   (bus.tx_done),
    .word      (bus.out_rdata),
    .tx_en     (bus.tx_en),
    .tx_data   (ser_data),
    .last_byte (ser_last)
  );

`ifdef NPU_SEQ_CHECKSUM_EN
  logic [BYTE_W-1:0] cks_q;
  logic              cks_ph;

  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      cks_q  <= '0;
      cks_ph <= 1'b0;
    end else begin
      if (ser_fire && !cks_ph) cks_q <= cks_q ^ ser_data;
      if (send_last) cks_ph <= 1'b1;
    end
  end

  assign cks_pend    = !cks_ph;
  assign bus.tx_data = cks_ph ? cks_q : ser_data;
`else
  assign cks_pend    = 1'b0;
  assign bus.tx_data = ser_data;
`endif

  assign bus.in_we       = in_we_q;
  assign bus.in_addr     = in_addr_c;
  assign bus.in_wdata    = in_wdata_q;
  assign bus.npu_en      = npu_en_c;
  assign bus.out_we      = out_we_c;
  assign bus.out_addr    = out_addr_c;
  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.err_overrun = err_q;
endmodule

// File: tb/tb_npu_seq_ctrl.sv
// Directed bench for npu_seq_ctrl with IN_BYTES=8, OUT_WORDS=2, LANES=4.
module tb_npu_seq_ctrl;
  localparam int IN_BYTES = 8, OUT_WORDS = 2, LANES = 4, ADDR_W = 16;
`ifdef NPU_SEQ_CHECKSUM_EN
  localparam int N_TX = 17;
`else
  localparam int N_TX = 16;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  npu_seq_ctrl_if #(.LANES(LANES), .ADDR_W(ADDR_W)) bus();

  npu_seq_ctrl #(.IN_BYTES(IN_BYTES), .OUT_WORDS(OUT_WORDS), .LANES(LANES), .ADDR_W(ADDR_W))
    dut (.clk(clk), .rst(rst), .bus(bus));

  logic [63:0] mem [2];
  logic [7:0]  exp_tx [0:16] = '{8'h05, 8'h00, 8'h06, 8'h00, 8'h07, 8'h00, 8'h08, 8'h00,
                                 8'h01, 8'h9A, 8'hFF, 8'h00, 8'hCD, 8'hAB, 8'h34, 8'h12,
                                 8'h28};
  int n_chk = 0, n_pass = 0;

  // Environment: sync-read output memory, NPU answering 5 cycles after npu_en,
  // UART TX answering 3 cycles after tx_en.
  int cyc = 0, npu_cnt = 0, tx_cnt = 0;
  always @(posedge clk) begin
    cyc           <= cyc + 1;
    bus.out_rdata <= mem[bus.out_addr[0]];
    npu_cnt       <= bus.npu_en ? npu_cnt + 1 : 0;
    bus.npu_done  <= bus.npu_en && npu_cnt == 4;
    if (bus.tx_en) tx_cnt <= 3;
    else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
    bus.tx_done   <= (tx_cnt == 2);
  end

  logic [ADDR_W-1:0] we_addr[$], en_addr[$], ow_addr[$];
  logic [7:0]        we_data[$], tx_q[$];
  int gaps[$], en_cyc[$];
  int last_we_cyc = 0, gap_len = 0, tx_proto_bad = 0, ow_bad = 0;
  logic en_prev = 1'b0, in_gap = 1'b0, tx_open = 1'b0;

  always @(negedge clk) begin
    if (bus.in_we) begin
      we_addr.push_back(bus.in_addr);
      we_data.push_back(bus.in_wdata);
      last_we_cyc = cyc;
    end
    if (bus.npu_en && !en_prev) begin
      en_cyc.push_back(cyc);
      en_addr.push_back(bus.in_addr);
      if (in_gap) gaps.push_back(gap_len);
    end
    if (bus.npu_en) in_gap = 1'b0;
    else if (en_prev) begin in_gap = 1'b1; gap_len = 1; end
    else if (in_gap) gap_len++;
    en_prev = bus.npu_en;
    if (bus.out_we) ow_addr.push_back(bus.out_addr);
    if (bus.out_we && !(bus.npu_done && bus.npu_en)) ow_bad++;
    if (bus.tx_en) begin
      tx_q.push_back(bus.tx_data);
      if (tx_open) tx_proto_bad++;
      tx_open = 1'b1;
    end
    if (bus.tx_done) tx_open = 1'b0;
  end

  function automatic logic [54:0] outs();
    return {bus.in_we, bus.in_addr, bus.in_wdata, bus.npu_en, bus.out_we, bus.out_addr,
            bus.tx_data, bus.tx_en, bus.busy, bus.done, bus.err_overrun};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; tick(1); bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_done = 1'b1; bus.rx_data = b; tick(1); bus.rx_done = 1'b0; tick(2);
  endtask

  task automatic test_reset();
    int base;
    rst = 1'b1; tick(2);
    n_chk++; if (outs() !== 55'd0) $display("FAIL reset_outs got %h exp 0", outs()); else n_pass++;
    rst = 1'b0; tick(1);
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(8'hA0 + 8'(i));
    n_chk++; if (bus.in_addr !== 16'd2) $display("FAIL pre_reset_addr got %0d exp 2", bus.in_addr); else n_pass++;
    rst = 1'b1; tick(1);
    n_chk++; if (outs() !== 55'd0) $display("FAIL midload_reset_outs got %h exp 0", outs()); else n_pass++;
    rst = 1'b0;
    base = we_addr.size();
    tick(3);
    n_chk++; if (we_addr.size() !== base) $display("FAIL reset_no_write got %0d exp %0d", we_addr.size(), base); else n_pass++;
    n_chk++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL reset_idle got busy=%b done=%b exp 0 0", bus.busy, bus.done); else n_pass++;
  endtask

  task automatic test_load();
    int base;
    base = we_addr.size();
    pulse_start();
    for (int i = 0; i < IN_BYTES; i++) send_byte(8'h10 + 8'(i));
    n_chk++; if (we_addr.size() - base !== IN_BYTES) $display("FAIL load_count got %0d exp %0d", we_addr.size() - base, IN_BYTES); else n_pass++;
    for (int i = 0; i < IN_BYTES; i++) begin
      n_chk++;
      if (base + i >= we_addr.size() || we_addr[base+i] !== 16'(i) || we_data[base+i] !== 8'h10 + 8'(i))
        $display("FAIL load_wr[%0d] got addr=%0d data=%h exp addr=%0d data=%h",
                 i, we_addr[base+i], we_data[base+i], i, 8'h10 + 8'(i));
      else n_pass++;
    end
    n_chk++;
    if (en_cyc.size() < 1 || en_cyc[0] - last_we_cyc !== 1)
      $display("FAIL npu_en_latency got %0d exp 1", (en_cyc.size() < 1) ? -1 : en_cyc[0] - last_we_cyc);
    else n_pass++;
  endtask

  task automatic test_process();
    int wbase;
    wbase = we_addr.size();
    n_chk++; if (bus.npu_en !== 1'b1) $display("FAIL proc_npu_en got %b exp 1", bus.npu_en); else n_pass++;
    send_byte(8'hEE);
    n_chk++; if (bus.err_overrun !== 1'b1) $display("FAIL overrun_set got %b exp 1", bus.err_overrun); else n_pass++;
    for (int k = 0; k < 200 && ow_addr.size() < OUT_WORDS; k++) tick(1);
    tick(1);
    n_chk++;
    if (ow_addr.size() !== OUT_WORDS || ow_addr[0] !== 16'd0 || ow_addr[1] !== 16'd1)
      $display("FAIL out_we_addrs got n=%0d %0d,%0d exp n=2 0,1", ow_addr.size(), ow_addr[0], ow_addr[1]);
    else n_pass++;
    n_chk++;
    if (en_addr.size() !== OUT_WORDS || en_addr[0] !== 16'd0 || en_addr[1] !== 16'd2)
      $display("FAIL npu_in_addr got n=%0d %0d,%0d exp n=2 0,2", en_addr.size(), en_addr[0], en_addr[1]);
    else n_pass++;
    n_chk++; if (gaps.size() !== 1 || gaps[0] !== 1) $display("FAIL npu_gap got n=%0d len=%0d exp n=1 len=1", gaps.size(), gaps[0]); else n_pass++;
    n_chk++; if (ow_bad !== 0) $display("FAIL out_we_timing got %0d exp 0", ow_bad); else n_pass++;
    n_chk++; if (we_addr.size() !== wbase) $display("FAIL overrun_no_write got %0d exp %0d", we_addr.size(), wbase); else n_pass++;
  endtask

  task automatic test_send();
    int k;
    for (k = 0; k < 2000 && bus.done !== 1'b1; k++) tick(1);
    n_chk++; if (bus.done !== 1'b1) $display("FAIL send_timeout got done=%b exp 1 after %0d cycles", bus.done, k); else n_pass++;
    n_chk++; if (tx_q.size() !== N_TX) $display("FAIL tx_count got %0d exp %0d", tx_q.size(), N_TX); else n_pass++;
    for (int i = 0; i < N_TX; i++) begin
      n_chk++;
      if (i >= tx_q.size() || tx_q[i] !== exp_tx[i])
        $display("FAIL tx_byte[%0d] got %h exp %h", i, tx_q[i], exp_tx[i]);
      else n_pass++;
    end
    n_chk++; if (tx_proto_bad !== 0) $display("FAIL tx_handshake got %0d exp 0", tx_proto_bad); else n_pass++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL done_busy got %b exp 0", bus.busy); else n_pass++;
    n_chk++; if (bus.err_overrun !== 1'b1) $display("FAIL overrun_sticky got %b exp 1", bus.err_overrun); else n_pass++;
  endtask

  task automatic test_restart();
    int base;
    base = we_addr.size();
    pulse_start();
    n_chk++; if (bus.err_overrun !== 1'b0) $display("FAIL overrun_clear got %b exp 0", bus.err_overrun); else n_pass++;
    n_chk++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) $display("FAIL restart_state got busy=%b done=%b exp 1 0", bus.busy, bus.done); else n_pass++;
    send_byte(8'h55);
    pulse_start();
    send_byte(8'h66);
    n_chk++;
    if (we_addr.size() - base !== 2 || we_addr[base] !== 16'd0 || we_addr[base+1] !== 16'd1)
      $display("FAIL restart_addrs got n=%0d %0d,%0d exp n=2 0,1",
               we_addr.size() - base, we_addr[base], we_addr[base+1]);
    else n_pass++;
    n_chk++; if (tx_q.size() !== N_TX) $display("FAIL restart_no_tx got %0d exp %0d", tx_q.size(), N_TX); else n_pass++;
  endtask

  initial begin
    mem[0] = 64'h0008_0007_0006_0005;
    mem[1] = 64'h1234_ABCD_00FF_9A01;
    bus.start = 1'b0; bus.rx_done = 1'b0; bus.rx_data = 8'h00;
    test_reset();
    test_load();
    test_process();
    test_send();
    test_restart();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule
